// File: rtl/simple_fixed_ctrl_pkg.sv
// Shared types and constants for the simple_fixed issue/writeback controller.
//   HALFWORD        : halfword width in bits
//   SF_LATENCY      : default issue-to-writeback depth
//   Opcodes         : instruction opcodes seen by the fixed-point units
//   sf_stage_t      : one pipeline stage {valid, wr_en, rt_addr, data}
//   sf_supported()  : 1 for opcodes implemented by the simple_fixed datapath
package simple_fixed_ctrl_pkg;

   localparam int unsigned HALFWORD       = 16;
   localparam int unsigned SF_LATENCY     = 2;
   localparam int unsigned SF_REG_ADDR_WD = 7;
   localparam int unsigned SF_REG_DATA_WD = 128;

   typedef enum logic [5:0] {
      NOP                     = 6'd0,
      IMMEDIATE_LOAD_HALFWORD = 6'd1,
      IMMEDIATE_LOAD_WORD     = 6'd2,
      ADD_WORD                = 6'd3,
      AND_WORD                = 6'd4,
      OR_WORD                 = 6'd5
   } Opcodes;

   typedef struct packed {
      logic                      valid;
      logic                      wr_en;
      logic [SF_REG_ADDR_WD-1:0] rt_addr;
      logic [SF_REG_DATA_WD-1:0] data;
   } sf_stage_t;

   function automatic logic sf_supported(input Opcodes op);
      return (op == IMMEDIATE_LOAD_HALFWORD);
   endfunction

endpackage

// File: rtl/simple_fixed_ctrl_if.sv
// Dispatch/register-file bus of the simple_fixed controller.
//   issue_*   : instruction handshake from dispatch (valid/ready)
//   wb_*      : register-file write port handshake (valid/ready)
//   flush     : kill all in-flight instructions
//   chk_addr  : register probed by dispatch; chk_hit reports an in-flight writer
//   err_opcode: one-cycle pulse after an unsupported opcode is accepted
//   perf_*    : event counters, present only when SF_CTRL_PERF_EN is defined
// Modports: master = dispatch/register-file side, slave = controller.
interface simple_fixed_ctrl_if
   import simple_fixed_ctrl_pkg::*;
#(
   parameter int unsigned REG_ADDR_WD = SF_REG_ADDR_WD,
   parameter int unsigned REG_DATA_WD = SF_REG_DATA_WD
);
   logic                   issue_valid;
   logic                   issue_ready;
   Opcodes                 issue_opcode;
   logic [REG_ADDR_WD-1:0] issue_rt_addr;
   logic [REG_DATA_WD-1:0] issue_RA;
   logic [REG_DATA_WD-1:0] issue_RB;
   logic [9:0]             issue_I10;
   logic [15:0]            issue_I16;
   logic [17:0]            issue_I18;
   logic                   wb_valid;
   logic                   wb_ready;
   logic                   wb_wr_en;
   logic [REG_ADDR_WD-1:0] wb_rt_addr;
   logic [REG_DATA_WD-1:0] wb_data;
   logic                   flush;
   logic [REG_ADDR_WD-1:0] chk_addr;
   logic                   chk_hit;
   logic                   err_opcode;
`ifdef SF_CTRL_PERF_EN
   logic [31:0]            perf_issued;
   logic [31:0]            perf_stall;
`endif

   modport master (
      output issue_valid, issue_opcode, issue_rt_addr, issue_RA, issue_RB,
             issue_I10, issue_I16, issue_I18, wb_ready, flush, chk_addr,
      input  issue_ready, wb_valid, wb_wr_en, wb_rt_addr, wb_data, chk_hit,
             err_opcode
`ifdef SF_CTRL_PERF_EN
      , input perf_issued, perf_stall
`endif
   );

   modport slave (
      input  issue_valid, issue_opcode, issue_rt_addr, issue_RA, issue_RB,
             issue_I10, issue_I16, issue_I18, wb_ready, flush, chk_addr,
      output issue_ready, wb_valid, wb_wr_en, wb_rt_addr, wb_data, chk_hit,
             err_opcode
`ifdef SF_CTRL_PERF_EN
      , output perf_issued, perf_stall
`endif
   );

endinterface

// File: rtl/simple_fixed_ctrl_stage.sv
// sf_pipe_stage: one stage register of the simple_fixed writeback pipe.
//   clk, rst : clock, asynchronous active-high reset
//   en       : load d into q
//   clr      : invalidate the held entry (takes priority over en)
//   d, q     : stage contents {valid, wr_en, rt_addr, data}
module sf_pipe_stage
   import simple_fixed_ctrl_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   input  logic      en,
   input  logic      clr,
   input  sf_stage_t d,
   output sf_stage_t q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= '0;
      end else if (clr) begin
         q.valid <= 1'b0;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/simple_fixed_ctrl.sv
// simple_fixed_ctrl: issue/writeback sequencer for the simple_fixed datapath.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : dispatch + register-file bus (simple_fixed_ctrl_if.slave)
//   dp_*     : combinational drive to the simple_fixed datapath (0 when idle)
//   dp_RT    : datapath result, captured into the first stage on issue
// Optional macro SF_CTRL_PERF_EN adds perf_issued/perf_stall counters.
module simple_fixed_ctrl
   import simple_fixed_ctrl_pkg::*;
#(
   parameter int unsigned REG_ADDR_WD = SF_REG_ADDR_WD,
   parameter int unsigned REG_DATA_WD = SF_REG_DATA_WD,
   parameter int unsigned LATENCY     = SF_LATENCY
)(
   input  logic                   clk,
   input  logic                   rst,
   simple_fixed_ctrl_if.slave     bus,
   output Opcodes                 dp_opcode,
   output logic [REG_DATA_WD-1:0] dp_RA,
   output logic [REG_DATA_WD-1:0] dp_RB,
   output logic [9:0]             dp_I10,
   output logic [15:0]            dp_I16,
   output logic [17:0]            dp_I18,
   input  logic [REG_DATA_WD-1:0] dp_RT
);

   sf_stage_t st_q [LATENCY];
   sf_stage_t s1_in;
   logic      advance;
   logic      handshake;
   logic      chk_hit_c;
   logic      err_q;

   // The pipe moves as a whole; a held tail stalls every stage behind it.
   assign advance         = !st_q[LATENCY-1].valid || bus.wb_ready;
   assign bus.issue_ready = advance && !bus.flush;
   assign handshake       = bus.issue_valid && bus.issue_ready;

   always_comb begin
      dp_opcode = NOP;
      dp_RA     = '0;
      dp_RB     = '0;
      dp_I10    = '0;
      dp_I16    = '0;
      dp_I18    = '0;
      if (bus.issue_valid) begin
         dp_opcode = bus.issue_opcode;
         dp_RA     = bus.issue_RA;
         dp_RB     = bus.issue_RB;
         dp_I10    = bus.issue_I10;
         dp_I16    = bus.issue_I16;
         dp_I18    = bus.issue_I18;
      end
   end

   // Without a handshake the head loads a bubble rather than holding.
   always_comb begin
      s1_in = '0;
      if (handshake) begin
         s1_in.valid   = 1'b1;
         s1_in.wr_en   = sf_supported(bus.issue_opcode);
         s1_in.rt_addr = bus.issue_rt_addr;
         s1_in.data    = dp_RT;
      end
   end

   for (genvar g = 0; g < LATENCY; g++) begin : g_stage
      if (g == 0) begin : g_head
         sf_pipe_stage u_stage (
            .clk (clk),
            .rst (rst),
            .en  (advance),
            .clr (bus.flush),
            .d   (s1_in),
            .q   (st_q[g])
         );
      end else begin : g_tail
         sf_pipe_stage u_stage (
            .clk (clk),
            .rst (rst),
            .en  (advance),
            .clr (bus.flush),
            .d   (st_q[g-1]),
            .q   (st_q[g])
         );
      end
   end

   assign bus.wb_valid   = st_q[LATENCY-1].valid && !bus.flush;
   assign bus.wb_wr_en   = st_q[LATENCY-1].wr_en;
   assign bus.wb_rt_addr = st_q[LATENCY-1].rt_addr;
   assign bus.wb_data    = st_q[LATENCY-1].data;

   // The tail still counts while its writeback completes this cycle.
   always_comb begin
      chk_hit_c = 1'b0;
      for (int unsigned i = 0; i < LATENCY; i++) begin
         chk_hit_c = chk_hit_c || (st_q[i].valid && st_q[i].wr_en &&
                                   (st_q[i].rt_addr == bus.chk_addr));
      end
   end
   assign bus.chk_hit = chk_hit_c;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_q <= 1'b0;
      end else begin
         err_q <= handshake && !sf_supported(bus.issue_opcode);
      end
   end
   assign bus.err_opcode = err_q;

`ifdef SF_CTRL_PERF_EN
   logic [31:0] perf_issued_q;
   logic [31:0] perf_stall_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_issued_q <= '0;
         perf_stall_q  <= '0;
      end else begin
         if (handshake) begin
            perf_issued_q <= perf_issued_q + 32'd1;
         end
         if (bus.wb_valid && !bus.wb_ready) begin
            perf_stall_q <= perf_stall_q + 32'd1;
         end
      end
   end
   assign bus.perf_issued = perf_issued_q;
   assign bus.perf_stall  = perf_stall_q;
`endif

endmodule

// File: tb/tb_simple_fixed_ctrl.sv
// Self-checking bench for simple_fixed_ctrl (LATENCY = 2).
// Expected writebacks are queued at issue; a negedge monitor retires them.
module tb_simple_fixed_ctrl;
   import simple_fixed_ctrl_pkg::*;

   localparam logic [127:0] JUNK = {4{32'hDEADBEEF}};

   logic         clk;
   logic         rst;
   Opcodes       dp_opcode;
   logic [127:0] dp_RA;
   logic [127:0] dp_RB;
   logic [9:0]   dp_I10;
   logic [15:0]  dp_I16;
   logic [17:0]  dp_I18;
   logic [127:0] dp_RT;

   int n_checks = 0;
   int n_fail   = 0;
   logic [135:0] exp_q [$];

   simple_fixed_ctrl_if #(.REG_ADDR_WD(7), .REG_DATA_WD(128)) bus ();

   simple_fixed_ctrl #(.REG_ADDR_WD(7), .REG_DATA_WD(128), .LATENCY(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus.slave),
      .dp_opcode (dp_opcode),
      .dp_RA     (dp_RA),
      .dp_RB     (dp_RB),
      .dp_I10    (dp_I10),
      .dp_I16    (dp_I16),
      .dp_I18    (dp_I18),
      .dp_RT     (dp_RT)
   );

   // Stand-in for the simple_fixed datapath: ILH replicates I16 across RT.
   always_comb begin
      dp_RT = JUNK;
      if (dp_opcode == IMMEDIATE_LOAD_HALFWORD) dp_RT = {8{dp_I16}};
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && bus.wb_valid && bus.wb_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL wb_unexpected: got writeback rt=%0d, expected none", bus.wb_rt_addr);
         end else begin
            check("wb_entry", {120'd0, bus.wb_wr_en, bus.wb_rt_addr, bus.wb_data},
                  {120'd0, exp_q.pop_front()});
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Call #1 after a posedge; returns #1 after the accepting edge.
   task automatic do_issue(input Opcodes op, input logic [6:0] rt, input logic [15:0] i16,
                           input bit push, input logic [135:0] exp);
      bit done = 0;
      bus.issue_valid   = 1'b1;
      bus.issue_opcode  = op;
      bus.issue_rt_addr = rt;
      bus.issue_I16     = i16;
      bus.issue_RA      = {16{rt, 1'b0}};
      for (int c = 0; c < 50 && !done; c++) begin
         @(negedge clk);
         if (bus.issue_ready) begin
            check("dp_I16_pass", {240'd0, dp_I16}, {240'd0, i16});
            check("dp_RA_pass", {128'd0, dp_RA}, {128'd0, {16{rt, 1'b0}}});
            if (push) exp_q.push_back(exp);
            done = 1;
         end
         step();
      end
      if (!done) begin
         n_checks++;
         n_fail++;
         $display("FAIL issue_timeout: got issue_ready=0 for 50 cycles, expected 1");
      end
      bus.issue_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no completion, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1;
      bus.issue_valid = 0; bus.issue_opcode = NOP; bus.issue_rt_addr = '0;
      bus.issue_RA = '0; bus.issue_RB = '0; bus.issue_I10 = '0;
      bus.issue_I16 = '0; bus.issue_I18 = '0;
      bus.wb_ready = 1'b1; bus.flush = 1'b0; bus.chk_addr = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_wb_valid", {255'd0, bus.wb_valid}, 256'd0);
      check("rst_chk_hit", {255'd0, bus.chk_hit}, 256'd0);
      check("rst_err", {255'd0, bus.err_opcode}, 256'd0);
      step();
      rst = 1'b0;
      @(negedge clk);
      check("idle_issue_ready", {255'd0, bus.issue_ready}, 256'd1);
      check("idle_dp_I16_zero", {240'd0, dp_I16}, 256'd0);
      step();

      // Single ILH, two-cycle latency
      do_issue(IMMEDIATE_LOAD_HALFWORD, 7'd5, 16'h1234, 1, {1'b1, 7'd5, {8{16'h1234}}});
      @(negedge clk);
      check("lat_c1_wb_valid", {255'd0, bus.wb_valid}, 256'd0);
      check("ilh_err_low", {255'd0, bus.err_opcode}, 256'd0);
      check("idle_dp_I16_zero2", {240'd0, dp_I16}, 256'd0);
      step();
      @(negedge clk);
      check("lat_c2_wb_valid", {255'd0, bus.wb_valid}, 256'd1);
      step();
      @(negedge clk);
      check("lat_c3_wb_valid", {255'd0, bus.wb_valid}, 256'd0);
      step();

      // Back-to-back issues retire in order
      do_issue(IMMEDIATE_LOAD_HALFWORD, 7'd1, 16'h0001, 1, {1'b1, 7'd1, {8{16'h0001}}});
      do_issue(IMMEDIATE_LOAD_HALFWORD, 7'd2, 16'h0002, 1, {1'b1, 7'd2, {8{16'h0002}}});
      do_issue(IMMEDIATE_LOAD_HALFWORD, 7'd3, 16'h0003, 1, {1'b1, 7'd3, {8{16'h0003}}});
      repeat (4) step();

      // Writeback backpressure: pipe and outputs hold
      do_issue(IMMEDIATE_LOAD_HALFWORD, 7'd10, 16'h00AA, 1, {1'b1, 7'd10, {8{16'h00AA}}});
      do_issue(IMMEDIATE_LOAD_HALFWORD, 7'd11, 16'h00BB, 1, {1'b1, 7'd11, {8{16'h00BB}}});
      bus.wb_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("stall_issue_ready", {255'd0, bus.issue_ready}, 256'd0);
         check("stall_wb_valid", {255'd0, bus.wb_valid}, 256'd1);
         check("stall_wb_rt", {249'd0, bus.wb_rt_addr}, 256'd10);
         check("stall_wb_data", {128'd0, bus.wb_data}, {128'd0, {8{16'h00AA}}});
         step();
      end
      bus.wb_ready = 1'b1;
      repeat (4) step();

      // Flush kills rt=9 in flight
      do_issue(IMMEDIATE_LOAD_HALFWORD, 7'd9, 16'h0009, 0, '0);
      bus.chk_addr = 7'd9;
      bus.flush = 1'b1;
      @(negedge clk);
      check("flush_issue_ready", {255'd0, bus.issue_ready}, 256'd0);
      check("flush_wb_valid", {255'd0, bus.wb_valid}, 256'd0);
      step();
      bus.flush = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("post_flush_chk_hit", {255'd0, bus.chk_hit}, 256'd0);
         check("post_flush_wb_valid", {255'd0, bus.wb_valid}, 256'd0);
         step();
      end

      // Reset mid-flight
      do_issue(IMMEDIATE_LOAD_HALFWORD, 7'd20, 16'h0020, 0, '0);
`ifdef SF_CTRL_PERF_EN
      check("perf_issued", {224'd0, bus.perf_issued}, 256'd8);
      check("perf_stall", {224'd0, bus.perf_stall}, 256'd4);
`endif
      bus.chk_addr = 7'd20;
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("post_rst_wb_valid", {255'd0, bus.wb_valid}, 256'd0);
         check("post_rst_chk_hit", {255'd0, bus.chk_hit}, 256'd0);
         step();
      end

      // Hazard probe and unsupported opcode
      bus.chk_addr = 7'd17;
      @(negedge clk);
      check("chk_idle", {255'd0, bus.chk_hit}, 256'd0);
      step();
      do_issue(IMMEDIATE_LOAD_HALFWORD, 7'd17, 16'h0017, 1, {1'b1, 7'd17, {8{16'h0017}}});
      @(negedge clk);
      check("chk_hit_s1", {255'd0, bus.chk_hit}, 256'd1);
      step();
      @(negedge clk);
      check("chk_hit_s2_wb", {255'd0, bus.chk_hit}, 256'd1);
      step();
      @(negedge clk);
      check("chk_hit_gone", {255'd0, bus.chk_hit}, 256'd0);
      step();
      do_issue(ADD_WORD, 7'd17, 16'h0017, 1, {1'b0, 7'd17, JUNK});
      @(negedge clk);
      check("err_pulse", {255'd0, bus.err_opcode}, 256'd1);
      check("unsup_chk_s1", {255'd0, bus.chk_hit}, 256'd0);
      step();
      @(negedge clk);
      check("err_one_cycle", {255'd0, bus.err_opcode}, 256'd0);
      check("unsup_chk_s2", {255'd0, bus.chk_hit}, 256'd0);
      step();
      repeat (4) step();
`ifdef SF_CTRL_PERF_EN
      check("perf_issued_after_rst", {224'd0, bus.perf_issued}, 256'd2);
      check("perf_stall_after_rst", {224'd0, bus.perf_stall}, 256'd0);
`endif
      check("queue_drained", exp_q.size(), 256'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/simple_fixed_ctrl.md
Name: simple_fixed_ctrl

Overview:
Issue/writeback sequencer for the SPU-Lite simple fixed-point unit. It accepts one instruction per cycle from the dispatch stage over a valid/ready handshake and drives the combinational simple_fixed datapath. It carries the result and destination address through a LATENCY-deep pipeline and presents it to the register-file write port. It also supports pipeline flush and reports destination hazards to the dispatcher.

Parameters:
REG_ADDR_WD, 7, register address width (128-entry register file)
REG_DATA_WD, 128, register data width
LATENCY, 2, issue-to-writeback cycles; legal range 1..8

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
issue_valid  in  1  dispatch presents an instruction
issue_ready  out  1  controller accepts the instruction this cycle
issue_opcode  in  Opcodes  instruction opcode
issue_rt_addr  in  REG_ADDR_WD  destination register
issue_RA, issue_RB  in  REG_DATA_WD each  source operands
issue_I10 / issue_I16 / issue_I18  in  10/16/18  immediates
dp_opcode, dp_RA, dp_RB, dp_I10, dp_I16, dp_I18  out  same widths  drive to simple_fixed
dp_RT  in  REG_DATA_WD  datapath result
wb_valid  out  1  writeback entry valid
wb_ready  in  1  register file accepts writeback
wb_wr_en  out  1  write enable (0 for unsupported opcodes)
wb_rt_addr  out  REG_ADDR_WD  destination register
wb_data  out  REG_DATA_WD  result
flush  in  1  kill all in-flight instructions
chk_addr  in  REG_ADDR_WD  register address probed by dispatch
chk_hit  out  1  an in-flight instruction will write chk_addr
err_opcode  out  1  single-cycle pulse: unsupported opcode accepted

Behaviour:
- Reset: all stage valids 0, so wb_valid=0, chk_hit=0, err_opcode=0. Stage data and address registers are don't-care. issue_ready is combinational and becomes 1 once rst deasserts. Reset mid-operation discards all in-flight entries with no writeback.
- dp_* outputs are a combinational pass-through of issue_* whenever issue_valid=1. They are held at 0 when issue_valid=0.
- Pipeline: stages S1..S_LATENCY. Each stage holds {valid, wr_en, rt_addr, data}.
- advance = !S_LAT.valid || wb_ready. The whole pipe shifts only when advance=1. Bubbles are not collapsed.
- issue_ready = advance && !flush.
- Handshake (issue_valid && issue_ready): S1 <= {1, supported(opcode), issue_rt_addr, dp_RT}.
- If advance=1 with no handshake, S1 <= bubble (valid=0).
- Latency: a handshake at edge N produces wb_valid at cycle N+LATENCY when wb_ready is held 1.
- Writeback: wb_valid = S_LAT.valid && !flush. wb_wr_en, wb_rt_addr and wb_data come from S_LAT.
- A writeback completes when wb_valid && wb_ready. If wb_ready=0, the pipe holds and all outputs stay stable.
- Flush: at the next edge all stage valids clear. In the flush cycle, wb_valid is masked and issue is refused. Flush overrides a simultaneous handshake and a simultaneous wb_ready.
- supported(opcode): the opcode set implemented by simple_fixed (currently IMMEDIATE_LOAD_HALFWORD).
- Unsupported opcode: the instruction is accepted and travels the pipe with wr_en=0. err_opcode pulses for one cycle, registered, on the edge after acceptance.
- chk_hit: combinational OR over all stages of (valid && wr_en && rt_addr==chk_addr). The match does not depend on wb_ready. An entry completing writeback this cycle still reports a hit.
- Duplicate destinations in flight are permitted. Writeback order equals issue order.

Optional Feature:
Macro SF_CTRL_PERF_EN.
- Defined: adds outputs perf_issued[31:0] and perf_stall[31:0], both reset to 0.
  - perf_issued increments on each issue handshake.
  - perf_stall increments on each cycle with wb_valid && !wb_ready.
  - Both wrap modulo 2^32. flush does not clear them.
- Undefined: no ports and no counter logic are generated.

Decomposition:
- defines_pkg additions:
  - SF_LATENCY constant (2), used as the LATENCY default.
  - sf_stage_t packed struct {valid, wr_en, rt_addr, data}.
  - sf_supported() function returning 1 for opcodes implemented by simple_fixed.
- Opcodes and HALFWORD are already in the package.
- One sub-module: sf_pipe_stage, a single stage register with enable, clear (flush) and async reset. Instantiate it LATENCY times via generate.

Test Plan:
- Reset release, then issue IMMEDIATE_LOAD_HALFWORD, I16=16'h1234, rt=5, wb_ready=1 -> exactly 2 cycles later wb_valid=1, wb_wr_en=1, wb_rt_addr=5, wb_data=128'h1234 replicated 8 times.
- Back-to-back issues I16=16'h0001/16'h0002/16'h0003, rt=1/2/3 -> three consecutive wb_valid cycles, in order, data replicated 8 times each.
- After 2 issues, hold wb_ready=0 for 4 cycles -> issue_ready=0 and wb outputs stable the whole time; then wb_ready=1 -> both retire in order with no loss.
- Issue rt=9 at cycle N, flush at N+1 -> no wb_valid for rt=9, chk_addr=9 gives chk_hit=0 from N+2; also assert rst mid-flight -> no writeback.
- Issue rt=17 with chk_addr=17 -> chk_hit=1 for LATENCY cycles, then 0; an unsupported opcode to rt=17 -> chk_hit=0, err_opcode pulses once, writeback has wb_wr_en=0.
- With SF_CTRL_PERF_EN: 5 issues and 3 stall cycles -> perf_issued=5, perf_stall=3.
